// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared widths, CPSR flag positions, the register-index type
//                and the write-forwarding match helper for the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;

  // NZCV flag positions inside the CPSR word
  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // True when a write retiring this cycle targets the register being looked up
  function automatic logic fwd_hit(input logic we, input reg_idx_t wr_idx,
                                   input reg_idx_t rd_idx);
    return we && (wr_idx == rd_idx);
  endfunction

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Per-register and CPSR busy bits tracking in-flight producers.
//                A reservation on the same edge as a retire wins, because the
//                newer producer now owns the register. Lookups mask a register
//                that is retiring this cycle, since its value is bypassed.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  // retire side (writeback)
  input  logic     rd_write_en,
  input  reg_idx_t rd_num,
  input  logic     cpsr_write_en,
  // reserve side (decode)
  input  logic     rsv_en,
  input  reg_idx_t rsv_num,
  input  logic     rsv_cpsr,
  // lookups
  input  reg_idx_t rn_num,
  input  reg_idx_t rm_num,
  input  reg_idx_t md_num,
  output logic     rn_busy,
  output logic     rm_busy,
  output logic     md_busy,
  output logic     cpsr_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                r_busy_cpsr;
  logic                w_busy_cpsr_nxt;

  // Next-state per register: set by a reservation, otherwise held unless retired
  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_busy_bit
      logic w_set;
      logic w_clr;
      assign w_set         = rsv_en      && (rsv_num == REG_IDX_W'(i));
      assign w_clr         = rd_write_en && (rd_num  == REG_IDX_W'(i));
      assign w_busy_nxt[i] = w_set | (r_busy[i] & ~w_clr);
    end
  endgenerate

  // CPSR follows the same set-over-clear rule
  assign w_busy_cpsr_nxt = rsv_cpsr | (r_busy_cpsr & ~cpsr_write_en);

  // Busy state register; reset drops every pending reservation at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy      <= '0;
      r_busy_cpsr <= 1'b0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_busy_cpsr <= w_busy_cpsr_nxt;
    end
  end

  // Lookups report a retiring register as ready because its data is forwarded
  assign rn_busy   = r_busy[rn_num] & ~fwd_hit(rd_write_en, rd_num, rn_num);
  assign rm_busy   = r_busy[rm_num] & ~fwd_hit(rd_write_en, rd_num, rm_num);
  assign md_busy   = r_busy[md_num] & ~fwd_hit(rd_write_en, rd_num, md_num);
  assign cpsr_busy = r_busy_cpsr & ~cpsr_write_en;

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : Architectural register file plus CPSR. Three combinational
//                read ports with write-through bypass from writeback, and a
//                busy scoreboard so decode can stall on RAW hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  // read ports
  input  reg_file_pkg::reg_idx_t      rn_num,
  output logic [DATA_W-1:0]           rn_val,
  input  reg_file_pkg::reg_idx_t      rm_num,
  output logic [DATA_W-1:0]           rm_val,
  input  reg_file_pkg::reg_idx_t      md_num,
  output logic [DATA_W-1:0]           md_val,
  // writeback
  input  reg_file_pkg::reg_idx_t      rd_num,
  input  logic                        rd_write_en,
  input  logic [DATA_W-1:0]           rd_val,
  input  logic                        cpsr_write_en,
  input  logic [DATA_W-1:0]           cpsr_in,
  output logic [DATA_W-1:0]           cpsr_val,
  // reservations from decode
  input  logic                        rsv_en,
  input  reg_file_pkg::reg_idx_t      rsv_num,
  input  logic                        rsv_cpsr,
  // hazard status
  output logic                        rn_busy,
  output logic                        rm_busy,
  output logic                        md_busy,
  output logic                        cpsr_busy
);

  import reg_file_pkg::*;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_cpsr;

  // Register array; every entry including r15 is a plain general register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (rd_write_en) begin
      r_regs[rd_num] <= rd_val;
    end
  end

  // CPSR holder; may update on the same edge as a register write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpsr <= '0;
    end else if (cpsr_write_en) begin
      r_cpsr <= cpsr_in;
    end
  end

  // Read ports see a same-cycle write directly instead of the stale entry
  assign rn_val   = fwd_hit(rd_write_en, rd_num, rn_num) ? rd_val : r_regs[rn_num];
  assign rm_val   = fwd_hit(rd_write_en, rd_num, rm_num) ? rd_val : r_regs[rm_num];
  assign md_val   = fwd_hit(rd_write_en, rd_num, md_num) ? rd_val : r_regs[md_num];
  assign cpsr_val = cpsr_write_en ? cpsr_in : r_cpsr;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_write_en   (rd_write_en),
    .rd_num        (rd_num),
    .cpsr_write_en (cpsr_write_en),
    .rsv_en        (rsv_en),
    .rsv_num       (rsv_num),
    .rsv_cpsr      (rsv_cpsr),
    .rn_num        (rn_num),
    .rm_num        (rm_num),
    .md_num        (md_num),
    .rn_busy       (rn_busy),
    .rm_busy       (rm_busy),
    .md_busy       (md_busy),
    .cpsr_busy     (cpsr_busy)
  );

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Directed vector bench for reg_file: bypass reads, CPSR,
//                scoreboard set/clear ordering and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

  logic        clk;
  logic        reset_n;
  logic [3:0]  rn_num, rm_num, md_num, rd_num, rsv_num;
  logic [31:0] rn_val, rm_val, md_val, rd_val, cpsr_in, cpsr_val;
  logic        rd_write_en, cpsr_write_en, rsv_en, rsv_cpsr;
  logic        rn_busy, rm_busy, md_busy, cpsr_busy;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file #(.NUM_REGS(16), .DATA_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rn_num        (rn_num),
    .rn_val        (rn_val),
    .rm_num        (rm_num),
    .rm_val        (rm_val),
    .md_num        (md_num),
    .md_val        (md_val),
    .rd_num        (rd_num),
    .rd_write_en   (rd_write_en),
    .rd_val        (rd_val),
    .cpsr_write_en (cpsr_write_en),
    .cpsr_in       (cpsr_in),
    .cpsr_val      (cpsr_val),
    .rsv_en        (rsv_en),
    .rsv_num       (rsv_num),
    .rsv_cpsr      (rsv_cpsr),
    .rn_busy       (rn_busy),
    .rm_busy       (rm_busy),
    .md_busy       (md_busy),
    .cpsr_busy     (cpsr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd_we;
    logic [3:0]  rd_n;
    logic [31:0] rd_v;
    logic        cp_we;
    logic [31:0] cp_in;
    logic        rsv;
    logic [3:0]  rsv_n;
    logic        rsv_cp;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  md;
    logic [31:0] e_rn;
    logic [31:0] e_rm;
    logic [31:0] e_md;
    logic [31:0] e_cp;
    logic        e_rnb;
    logic        e_rmb;
    logic        e_mdb;
    logic        e_cpb;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    rd_write_en = 1'b0; rd_num = 4'd0; rd_val = 32'h0;
    cpsr_write_en = 1'b0; cpsr_in = 32'h0;
    rsv_en = 1'b0; rsv_num = 4'd0; rsv_cpsr = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    string tag;
    v = vecs[idx];
    @(negedge clk);
    rd_write_en = v.rd_we; rd_num = v.rd_n; rd_val = v.rd_v;
    cpsr_write_en = v.cp_we; cpsr_in = v.cp_in;
    rsv_en = v.rsv; rsv_num = v.rsv_n; rsv_cpsr = v.rsv_cp;
    rn_num = v.rn; rm_num = v.rm; md_num = v.md;
    #2;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".rn_val"},    rn_val,            v.e_rn);
    chk({tag, ".rm_val"},    rm_val,            v.e_rm);
    chk({tag, ".md_val"},    md_val,            v.e_md);
    chk({tag, ".cpsr_val"},  cpsr_val,          v.e_cp);
    chk({tag, ".rn_busy"},   {31'd0, rn_busy},  {31'd0, v.e_rnb});
    chk({tag, ".rm_busy"},   {31'd0, rm_busy},  {31'd0, v.e_rmb});
    chk({tag, ".md_busy"},   {31'd0, md_busy},  {31'd0, v.e_mdb});
    chk({tag, ".cpsr_busy"}, {31'd0, cpsr_busy},{31'd0, v.e_cpb});
  endtask

  // Safety net in case something stalls the stimulus process
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    //             rdwe  rdn    rdv           cpwe  cpin          rsv   rsvn   rsvcp rn     rm     md     e_rn          e_rm          e_md          e_cp          rnb   rmb   mdb   cpb
    // reset state, nothing written yet
    vecs[0]  = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    // write r5 with same-cycle bypass, then read back from storage
    vecs[1]  = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 4'd0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 4'd0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    // load r1..r3 and the CPSR, three-port read
    vecs[3]  = '{1'b1, 4'd1, 32'h1,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd1, 4'd2, 4'd3, 32'h1,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd2, 32'h2,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd1, 4'd2, 4'd3, 32'h1,        32'h2,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd3, 32'h3,        1'b1, 32'h60000000, 1'b0, 4'd0, 1'b0, 4'd1, 4'd2, 4'd3, 32'h1,        32'h2,        32'h3,        32'h60000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd1, 4'd2, 4'd3, 32'h1,        32'h2,        32'h3,        32'h60000000, 1'b0, 1'b0, 1'b0, 1'b0};
    // reserve r7, busy appears after the edge, retire two cycles later
    vecs[7]  = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b1, 4'd7, 1'b0, 4'd1, 4'd7, 4'd3, 32'h1,        32'h0,        32'h3,        32'h60000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd1, 4'd7, 4'd3, 32'h1,        32'h0,        32'h3,        32'h60000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd1, 4'd7, 4'd3, 32'h1,        32'h0,        32'h3,        32'h60000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd7, 32'hCAFE0007, 1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd1, 4'd7, 4'd3, 32'h1,        32'hCAFE0007, 32'h3,        32'h60000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd1, 4'd7, 4'd3, 32'h1,        32'hCAFE0007, 32'h3,        32'h60000000, 1'b0, 1'b0, 1'b0, 1'b0};
    // r4: reserve, then retire and re-reserve on the same edge (set wins)
    vecs[12] = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b1, 4'd4, 1'b0, 4'd4, 4'd7, 4'd3, 32'h0,        32'hCAFE0007, 32'h3,        32'h60000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd4, 4'd7, 4'd3, 32'h0,        32'hCAFE0007, 32'h3,        32'h60000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'd4, 32'h00000044, 1'b0, 32'h0,        1'b1, 4'd4, 1'b0, 4'd4, 4'd7, 4'd3, 32'h44,       32'hCAFE0007, 32'h3,        32'h60000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd4, 4'd7, 4'd3, 32'h44,       32'hCAFE0007, 32'h3,        32'h60000000, 1'b1, 1'b0, 1'b0, 1'b0};
    // CPSR hazard
    vecs[16] = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 4'd4, 4'd7, 4'd3, 32'h44,       32'hCAFE0007, 32'h3,        32'h60000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd4, 4'd7, 4'd3, 32'h44,       32'hCAFE0007, 32'h3,        32'h60000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 4'd0, 32'h0,        1'b1, 32'h80000000, 1'b0, 4'd0, 1'b0, 4'd4, 4'd7, 4'd3, 32'h44,       32'hCAFE0007, 32'h3,        32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd4, 4'd7, 4'd3, 32'h44,       32'hCAFE0007, 32'h3,        32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0};
    // unreserved write to r9 leaves it not busy
    vecs[20] = '{1'b1, 4'd9, 32'h00000099, 1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd9, 4'd4, 4'd7, 32'h99,       32'h44,       32'hCAFE0007, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd9, 4'd4, 4'd7, 32'h99,       32'h44,       32'hCAFE0007, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
    // re-reserving busy r4 keeps it busy; r15 behaves like any register
    vecs[22] = '{1'b1, 4'd15,32'hF00DF00D, 1'b0, 32'h0,        1'b1, 4'd4, 1'b0, 4'd4, 4'd15,4'd7, 32'h44,       32'hF00DF00D, 32'hCAFE0007, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd4, 4'd15,4'd7, 32'h44,       32'hF00DF00D, 32'hCAFE0007, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0};
    // CPSR retire and reserve together: set wins
    vecs[24] = '{1'b0, 4'd0, 32'h0,        1'b1, 32'h10000000, 1'b0, 4'd0, 1'b1, 4'd4, 4'd15,4'd7, 32'h44,       32'hF00DF00D, 32'hCAFE0007, 32'h10000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd4, 4'd15,4'd7, 32'h44,       32'hF00DF00D, 32'hCAFE0007, 32'h10000000, 1'b1, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0;
    drive_idle();
    rn_num = 4'd0; rm_num = 4'd0; md_num = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(i);
    end

    // Mid-run asynchronous reset: r3 = 0x1234 first, with r4 and CPSR busy
    @(negedge clk);
    drive_idle();
    rd_write_en = 1'b1; rd_num = 4'd3; rd_val = 32'h00001234;
    @(negedge clk);
    drive_idle();
    rn_num = 4'd3; rm_num = 4'd4; md_num = 4'd15;
    #2;
    chk("pre_rst.rn_val",    rn_val,              32'h00001234);
    chk("pre_rst.rm_busy",   {31'd0, rm_busy},    32'd1);
    chk("pre_rst.cpsr_busy", {31'd0, cpsr_busy},  32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst.rn_val",    rn_val,             32'h0);
    chk("async_rst.rm_val",    rm_val,             32'h0);
    chk("async_rst.md_val",    md_val,             32'h0);
    chk("async_rst.cpsr_val",  cpsr_val,           32'h0);
    chk("async_rst.rn_busy",   {31'd0, rn_busy},   32'd0);
    chk("async_rst.rm_busy",   {31'd0, rm_busy},   32'd0);
    chk("async_rst.md_busy",   {31'd0, md_busy},   32'd0);
    chk("async_rst.cpsr_busy", {31'd0, cpsr_busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // After release the file works again and r3 stays cleared
    @(negedge clk);
    rd_write_en = 1'b1; rd_num = 4'd2; rd_val = 32'hA5A5A5A5;
    rsv_en = 1'b1; rsv_num = 4'd3;
    rn_num = 4'd2; rm_num = 4'd3;
    #2;
    chk("post_rst.rn_val", rn_val, 32'hA5A5A5A5);
    chk("post_rst.rm_val", rm_val, 32'h0);
    @(negedge clk);
    drive_idle();
    #2;
    chk("post_rst.rn_val2",  rn_val,            32'hA5A5A5A5);
    chk("post_rst.rm_busy",  {31'd0, rm_busy},  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_file
`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file and CPSR holder on the receiving end of the writeback stage's rd/cpsr write interface.
- Serves three combinational read ports to decode: rn, rm, and md (store data).
- Write-through bypass: a value written in cycle N is visible to a read in the same cycle N.
- A per-register busy scoreboard lets decode stall on RAW hazards until writeback retires the producer.

Parameters:
- NUM_REGS, 16, number of general registers; index width is clog2(NUM_REGS) = 4.
- DATA_W, 32, register and CPSR width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rn_num  in  4  read port A index.
- rn_val  out  32  read port A data.
- rm_num  in  4  read port B index.
- rm_val  out  32  read port B data.
- md_num  in  4  read port C index (store data).
- md_val  out  32  read port C data.
- rd_num  in  4  write index from writeback.
- rd_write_en  in  1  write strobe from writeback.
- rd_val  in  32  write data from writeback.
- cpsr_write_en  in  1  CPSR write strobe from writeback.
- cpsr_in  in  32  CPSR data from writeback (NZCV in [31:28]).
- cpsr_val  out  32  current CPSR (bypassed).
- rsv_en  in  1  decode reserves rsv_num as pending destination.
- rsv_num  in  4  register to reserve.
- rsv_cpsr  in  1  decode reserves CPSR (cmp issued).
- rn_busy  out  1  rn_num has a pending write.
- rm_busy  out  1  rm_num has a pending write.
- md_busy  out  1  md_num has a pending write.
- cpsr_busy  out  1  CPSR has a pending write.

Behaviour:
- Clock and reset: single clk; reset_n is asynchronous and active-low. While reset_n = 0, all regs, the CPSR, and all busy bits = 0.
- Writes: on a rising edge with rd_write_en = 1, regs[rd_num] <= rd_val. On a rising edge with cpsr_write_en = 1, cpsr <= cpsr_in. Both may fire in the same cycle.
- Reads: zero-latency combinational.
  - x_val = rd_val if rd_write_en and rd_num == x_num; otherwise regs[x_num].
  - cpsr_val = cpsr_in if cpsr_write_en; otherwise cpsr.
- Read outputs after reset: all read outputs show 0 until the first write.
- Scoreboard: busy[NUM_REGS] plus busy_cpsr, evaluated at each rising edge in this order:
  - Clear: rd_write_en clears busy[rd_num]; cpsr_write_en clears busy_cpsr.
  - Set: rsv_en sets busy[rsv_num]; rsv_cpsr sets busy_cpsr.
  - Set wins over clear on the same index in the same edge (the newer producer owns the register).
- Busy outputs:
  - x_busy = busy[x_num] & ~(rd_write_en & rd_num == x_num). A register retiring this cycle is reported not busy because its value is bypassed.
  - cpsr_busy = busy_cpsr & ~cpsr_write_en.
- Writes with no prior reservation are legal: data is written, busy stays 0.
- Re-reserving an already-busy register keeps it at 1 (no counting). At most one in-flight producer per register is permitted; decode must enforce this.
- All registers are general; r15 gets no special treatment.
- Reset asserted mid-operation discards pending writes and clears all busy bits immediately, without waiting for clk.

Decomposition:
- Shared package holds:
  - REG_IDX_W = 4 and DATA_W = 32.
  - CPSR flag bit positions: N = 31, Z = 30, C = 29, V = 28.
  - The register-index typedef.
- One natural sub-module: reg_scoreboard. It owns the busy bits, the set/clear priority, and the three read-port busy lookups with retire masking. reg_file instantiates it beside the storage array and bypass muxes.

Test Plan:
1. Reset: assert reset_n = 0 mid-run after writing r3 = 0x1234 -> rn_val for r3 = 0, all busy = 0, cpsr_val = 0 immediately, no clock edge needed.
2. Write then read: edge N writes r5 = 0xDEADBEEF; in the same cycle rn_num = 5 -> rn_val = 0xDEADBEEF (bypass); in cycle N+1 with rd_write_en = 0 -> still 0xDEADBEEF.
3. Three-port read with CPSR: r1 = 1, r2 = 2, r3 = 3; rn/rm/md select 1/2/3 -> 1/2/3. cpsr_write_en with cpsr_in = 0x60000000 -> cpsr_val = 0x60000000 that cycle and after.
4. Scoreboard: rsv_en with rsv_num = 7 -> next cycle rm_busy = 1 for rm_num = 7; two cycles later rd_write_en with rd_num = 7 -> rm_busy = 0 that cycle and rm_val = rd_val; busy[7] = 0 after the edge.
5. Simultaneous retire and reserve on r4 in the same edge -> r4 data updated, busy[4] = 1 after the edge.
6. CPSR hazard: rsv_cpsr -> cpsr_busy = 1 until cpsr_write_en; a write to rd_num = 9 with no reservation -> data written, rn_busy for r9 stays 0.
